i2c_wr_master: RTL

- Single-master I2C write engine on the far side of the exec / word_addr / wdata / i2c_done handshake used by the OLED command/data sequencer.
- Each accepted exec produces one 3-byte write frame on the bus: START, device byte {DEV_ADDR,0}, word_addr, wdata, STOP.
- Pulses i2c_done when the frame ends and flags a slave NACK.
- SCL is driven push-pull (sole master); SDA is open-drain.

---
 rtl/i2c_wr_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/i2c_wr_master.sv
// i2c_wr_master: single-master I2C 3-byte write engine (START, {DEV_ADDR,0}, word_addr, wdata, STOP); define I2C_ACK_CHK_EN to abort on NACK and report ack_err
module i2c_wr_master #(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 400_000,
  parameter logic [6:0] DEV_ADDR     = 7'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exec,
  input  logic [7:0] word_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       i2c_done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);
  localparam int DIV = SYS_CLK_FREQ / (4 * SCL_FREQ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic [1:0]    r_q, r_idx;
  logic [2:0]    r_bit;
  logic [7:0]    r_waddr, r_wdata, w_byte;
  logic          r_busy, r_done, r_scl, r_sda_low;
  logic          w_tick, w_acc, w_slot_end, w_last, w_scl, w_sda_low, w_nack;

  assign w_tick     = r_div == DW'(DIV - 1);
  assign w_acc      = (r_state == S_IDLE) && exec;
  assign w_slot_end = w_tick && (r_q == 2'd3);
  assign w_byte     = (r_idx == 2'd0) ? {DEV_ADDR, 1'b0} : (r_idx == 2'd1) ? r_waddr : r_wdata;
  assign w_last     = w_nack || (r_idx == 2'd2);

  assign busy     = r_busy;
  assign i2c_done = r_done;
  assign scl      = r_scl;
  assign sda      = r_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_ACK_CHK_EN
  logic r_nack, r_ack_err;
  assign w_nack  = r_nack;
  assign ack_err = r_ack_err;
  // NACK capture at ACK q2 (released sda reads high) and reporting at frame end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_nack    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      if (w_acc) r_nack <= 1'b0;
      else if (r_state == S_ACK && w_tick && r_q == 2'd2 && sda) r_nack <= 1'b1;
      if (r_state == S_DONE) r_ack_err <= r_nack;
    end
`else
  assign w_nack  = 1'b0;
  assign ack_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  // next state and bus levels per (state, quarter)
  always_comb begin
    w_next    = r_state;
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      S_IDLE:  w_next = exec ? S_START : S_IDLE;
      S_START: begin
        w_scl     = ~r_q[1];
        w_sda_low = r_q != 2'd0;
        if (w_slot_end) w_next = S_BYTE;
      end
      S_BYTE:  begin
        w_scl     = r_q[0] ^ r_q[1];
        w_sda_low = ~w_byte[3'd7 - r_bit];
        if (w_slot_end && r_bit == 3'd7) w_next = S_ACK;
      end
      S_ACK:   begin
        w_scl = r_q[0] ^ r_q[1];
        if (w_slot_end) w_next = w_last ? S_STOP : S_BYTE;
      end
      S_STOP:  begin
        w_scl     = r_q != 2'd0;
        w_sda_low = ~r_q[1];
        if (w_slot_end) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // quarter divider, slot/bit/byte counters and input latch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div   <= '0;
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
      r_idx   <= 2'd0;
      r_waddr <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      r_div   <= (w_acc || w_tick) ? '0 : r_div + 1'b1;
      r_q     <= w_acc ? 2'd0 : w_tick ? r_q + 2'd1 : r_q;
      r_bit   <= w_acc ? 3'd0 : (r_state == S_BYTE && w_slot_end) ? r_bit + 3'd1 : r_bit;
      r_idx   <= w_acc ? 2'd0 : (r_state == S_ACK && w_slot_end) ? r_idx + 2'd1 : r_idx;
      r_waddr <= w_acc ? word_addr : r_waddr;
      r_wdata <= w_acc ? wdata : r_wdata;
    end

  // registered handshake and bus outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
    end else begin
      r_busy    <= w_acc ? 1'b1 : (r_state == S_DONE) ? 1'b0 : r_busy;
      r_done    <= r_state == S_DONE;
      r_scl     <= w_scl;
      r_sda_low <= w_sda_low;
    end
endmodule
